// File: rtl/matrix_apb_driver_if.sv
// APB requester/completer bundle between matrix_apb_driver and the
// accelerator's completer port.
//   master : drives psel, penable, pwrite, paddr, pwdata; samples prdata, pready, pslverr
//   slave  : the mirror image, for the accelerator side or a bench model
interface matrix_apb_driver_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/matrix_apb_driver.sv
// matrix_apb_driver
// Host-side APB requester for the matrix accelerator. One job runs as follows:
// stream N_LOAD operand words into the load window, write 1 to the start
// register, poll the status register until bit0 is set, then read N_RESULT
// result words out onto a valid/ready stream.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   job_start             pulse that starts a job (ignored while busy)
//   busy, job_done        job in progress; 1-cycle pulse at the end of a job
//   job_err               sticky error flag, cleared by the next accepted job_start
//   in_valid/in_data/in_ready      operand stream (sink side)
//   res_valid/res_data/res_ready   result stream (source side)
//   apb                   APB requester (master modport of matrix_apb_driver_if)
//
// Build option
//   MATRIX_APB_TMO_EN  when defined, a wait of TMO_CYC cycles with pready low
//                      aborts the job as if pslverr had been returned.
//
// state    | meaning
// IDLE     | waiting for job_start
// LD_WAIT  | waiting for an operand word on the input stream
// LD_SETUP | APB setup phase, operand write
// LD_ACC   | APB access phase, operand write
// ST_SETUP | APB setup phase, start-register write
// ST_ACC   | APB access phase, start-register write
// PL_SETUP | APB setup phase, status read
// PL_ACC   | APB access phase, status read
// RD_SETUP | APB setup phase, result read
// RD_ACC   | APB access phase, result read
// RD_HOLD  | result word presented, waiting for res_ready
// DONE     | one-cycle job_done pulse
module matrix_apb_driver #(
    parameter int              ADDR_W    = 8,
    parameter int              DATA_W    = 32,
    parameter int              N_LOAD    = 16,
    parameter int              N_RESULT  = 16,
    parameter logic [ADDR_W-1:0] LOAD_BASE = 8'h00,
    parameter logic [ADDR_W-1:0] RES_BASE  = 8'h40,
    parameter logic [ADDR_W-1:0] CTRL_ADDR = 8'h80,
    parameter logic [ADDR_W-1:0] STAT_ADDR = 8'h84,
    parameter int              TMO_CYC   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_start,
    output logic              busy,
    output logic              job_done,
    output logic              job_err,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    input  logic              res_ready,
    matrix_apb_driver_if.master apb
);

    if (N_LOAD < 1 || N_LOAD > 255 || N_RESULT < 1 || N_RESULT > 255 ||
        TMO_CYC < 1 || TMO_CYC > 255) begin : g_param_check
        $error("matrix_apb_driver: N_LOAD, N_RESULT and TMO_CYC must be in 1..255");
    end

    typedef enum logic [3:0] {
        IDLE, LD_WAIT, LD_SETUP, LD_ACC, ST_SETUP, ST_ACC,
        PL_SETUP, PL_ACC, RD_SETUP, RD_ACC, RD_HOLD, DONE
    } state_t;

    localparam logic [7:0] N_LOAD_C   = 8'(N_LOAD);
    localparam logic [7:0] N_RESULT_C = 8'(N_RESULT);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] paddr_q, paddr_nxt;
    logic [DATA_W-1:0] pwdata_q, pwdata_nxt;
    logic [DATA_W-1:0] res_data_q, res_data_nxt;
    logic [7:0]        ld_cnt, ld_cnt_nxt;
    logic [7:0]        rd_cnt, rd_cnt_nxt;
    logic              job_err_q, job_err_nxt;
    logic              in_setup, in_acc;
    logic              acc_tmo, acc_done, acc_err;

    // Word address: base + 4*count, wrapping silently within ADDR_W.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                     input logic [7:0] cnt);
        logic [ADDR_W+9:0] sum;
        sum = {10'd0, base} + {{ADDR_W{1'b0}}, cnt, 2'b00};
        return sum[ADDR_W-1:0];
    endfunction

    assign in_setup = (state == LD_SETUP) || (state == ST_SETUP) ||
                      (state == PL_SETUP) || (state == RD_SETUP);
    assign in_acc   = (state == LD_ACC) || (state == ST_ACC) ||
                      (state == PL_ACC) || (state == RD_ACC);

`ifdef MATRIX_APB_TMO_EN
    localparam logic [7:0] TMO_LIM = 8'(TMO_CYC);
    logic [7:0] wait_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 8'd0;
        end else if (in_setup) begin
            wait_cnt <= 8'd0;
        end else if (in_acc && !apb.pready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Fires on the TMO_CYC-th consecutive access cycle without pready.
    assign acc_tmo = in_acc && !apb.pready && (wait_cnt + 8'd1 == TMO_LIM);
`else
    assign acc_tmo = 1'b0;
`endif

    assign acc_done = apb.pready || acc_tmo;
    assign acc_err  = (apb.pready && apb.pslverr) || acc_tmo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            res_data_q <= '0;
            ld_cnt     <= 8'd0;
            rd_cnt     <= 8'd0;
            job_err_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            paddr_q    <= paddr_nxt;
            pwdata_q   <= pwdata_nxt;
            res_data_q <= res_data_nxt;
            ld_cnt     <= ld_cnt_nxt;
            rd_cnt     <= rd_cnt_nxt;
            job_err_q  <= job_err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        paddr_nxt    = paddr_q;
        pwdata_nxt   = pwdata_q;
        res_data_nxt = res_data_q;
        ld_cnt_nxt   = ld_cnt;
        rd_cnt_nxt   = rd_cnt;
        job_err_nxt  = job_err_q;

        case (state)
            IDLE: begin
                if (job_start) begin
                    state_nxt   = LD_WAIT;
                    ld_cnt_nxt  = 8'd0;
                    rd_cnt_nxt  = 8'd0;
                    job_err_nxt = 1'b0;
                end
            end
            LD_WAIT: begin
                if (in_valid) begin
                    pwdata_nxt = in_data;
                    paddr_nxt  = word_addr(LOAD_BASE, ld_cnt);
                    state_nxt  = LD_SETUP;
                end
            end
            LD_SETUP: state_nxt = LD_ACC;
            ST_SETUP: state_nxt = ST_ACC;
            PL_SETUP: state_nxt = PL_ACC;
            RD_SETUP: state_nxt = RD_ACC;
            LD_ACC: begin
                if (acc_err) begin
                    job_err_nxt = 1'b1;
                    state_nxt   = DONE;
                end else if (acc_done) begin
                    ld_cnt_nxt = ld_cnt + 8'd1;
                    if (ld_cnt + 8'd1 == N_LOAD_C) begin
                        paddr_nxt  = CTRL_ADDR;
                        pwdata_nxt = DATA_W'(1);
                        state_nxt  = ST_SETUP;
                    end else begin
                        state_nxt = LD_WAIT;
                    end
                end
            end
            ST_ACC: begin
                if (acc_err) begin
                    job_err_nxt = 1'b1;
                    state_nxt   = DONE;
                end else if (acc_done) begin
                    paddr_nxt = STAT_ADDR;
                    state_nxt = PL_SETUP;
                end
            end
            PL_ACC: begin
                if (acc_err) begin
                    job_err_nxt = 1'b1;
                    state_nxt   = DONE;
                end else if (acc_done) begin
                    if (apb.prdata[0]) begin
                        paddr_nxt = word_addr(RES_BASE, rd_cnt);
                        state_nxt = RD_SETUP;
                    end else begin
                        state_nxt = PL_SETUP;
                    end
                end
            end
            RD_ACC: begin
                if (acc_err) begin
                    job_err_nxt = 1'b1;
                    state_nxt   = DONE;
                end else if (acc_done) begin
                    res_data_nxt = apb.prdata;
                    state_nxt    = RD_HOLD;
                end
            end
            RD_HOLD: begin
                if (res_ready) begin
                    rd_cnt_nxt = rd_cnt + 8'd1;
                    if (rd_cnt + 8'd1 == N_RESULT_C) begin
                        state_nxt = DONE;
                    end else begin
                        paddr_nxt = word_addr(RES_BASE, rd_cnt + 8'd1);
                        state_nxt = RD_SETUP;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // APB control is decoded from state so that reset removes psel at once.
    assign apb.psel    = in_setup || in_acc;
    assign apb.penable = in_acc;
    assign apb.pwrite  = (state == LD_SETUP) || (state == LD_ACC) ||
                         (state == ST_SETUP) || (state == ST_ACC);
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;

    assign busy      = (state != IDLE) && (state != DONE);
    assign job_done  = (state == DONE);
    assign job_err   = job_err_q;
    assign in_ready  = (state == LD_WAIT);
    assign res_valid = (state == RD_HOLD);
    assign res_data  = res_data_q;

endmodule
